// File: rtl/intc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : intc_pkg                                                        |
// | Purpose  : Shared types and constants for the IO interrupt controller:     |
// |            handshake FSM state encoding, select-id width helper and the    |
// |            default vector base.                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package intc_pkg;

    // Vector presented for source 0; source i gets c_VEC_BASE + 4*i.
    localparam logic [31:0] c_VEC_BASE = 32'h0000_0F00;

    // Handshake FSM encoding.
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_ACK  = 2'd2;
    localparam logic [1:0] c_ST_WAIT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = c_ST_IDLE,
        REQ  = c_ST_REQ,
        ACK  = c_ST_ACK,
        WAIT = c_ST_WAIT
    } intc_state_t;

    // Width of a source index; never below 1 so a single-source build still
    // has a legal vector.
    function automatic int INTC_ID_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/intc_prio_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : intc_prio_sel                                                   |
// | Purpose  : Combinational priority select over the eligible request set.    |
// |            Fixed mode: lowest index wins.                                  |
// |            INTC_ROTATE_PRIO_EN: source rr_ptr is highest, then rr_ptr+1,   |
// |            wrapping modulo NUM_SRC.                                        |
// | Ports    : elig   in  NUM_SRC  pending & ~mask                             |
// |            rr_ptr in  ID_W     rotation start (INTC_ROTATE_PRIO_EN only)   |
// |            any    out 1        at least one source eligible                |
// |            sel_id out ID_W     index of the winning source                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module intc_prio_sel
    import intc_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = INTC_ID_W(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] elig,
`ifdef INTC_ROTATE_PRIO_EN
    input  logic [ID_W-1:0]    rr_ptr,
`endif
    output logic               any,
    output logic [ID_W-1:0]    sel_id
);

    assign any = |elig;

`ifdef INTC_ROTATE_PRIO_EN
    // Each source's distance from the pointer (mod NUM_SRC); the eligible
    // source with the smallest distance wins. Indexing by the constant loop
    // variable keeps the mux free of a variable rotate.
    int w_dist;
    int w_best;

    always_comb begin
        sel_id = '0;
        w_dist = 0;
        w_best = NUM_SRC;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_dist = (i + NUM_SRC - int'(rr_ptr)) % NUM_SRC;
            if (elig[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                sel_id = ID_W'(i);
            end
        end
    end
`else
    // Scan high to low so the lowest eligible index is the last one written.
    always_comb begin
        sel_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel_id = ID_W'(i);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/io_intr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : io_intr_ctrl                                                    |
// | Purpose  : Interrupt controller between the IO modules' intr lines and     |
// |            the CPU interrupt pin. Edge-latches requests into pending,      |
// |            masks them, picks one by priority, runs the intr/inta           |
// |            handshake, presents the vector and pulses int_ack to the        |
// |            serviced source.                                                |
// | Ports    : clock    in  1        system clock                              |
// |            reset    in  1        synchronous, active-high                  |
// |            irq_in   in  NUM_SRC  level intr lines, rising edges latched    |
// |            int_ack  out NUM_SRC  one-hot, one-cycle acknowledge            |
// |            mask_wr  in  1        load mask register                        |
// |            mask_in  in  NUM_SRC  new mask, 1 = source disabled             |
// |            cpu_intr out 1        interrupt request to the CPU              |
// |            cpu_inta in  1        CPU acknowledge (level)                   |
// |            int_vec  out VEC_W    vector of the serviced source             |
// |            pending  out NUM_SRC  raw pending register                      |
// | Config   : INTC_ROTATE_PRIO_EN  round-robin priority (default: fixed)      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module io_intr_ctrl
    import intc_pkg::*;
#(
    parameter int               NUM_SRC  = 4,
    parameter int               VEC_W    = 32,
    parameter logic [VEC_W-1:0] VEC_BASE = VEC_W'(c_VEC_BASE)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic [NUM_SRC-1:0] int_ack,
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_in,
    output logic               cpu_intr,
    input  logic               cpu_inta,
    output logic [VEC_W-1:0]   int_vec,
    output logic [NUM_SRC-1:0] pending
);

    localparam int c_ID_W = INTC_ID_W(NUM_SRC);

    logic [NUM_SRC-1:0] r_irq_q;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] w_elig;
    logic [NUM_SRC-1:0] w_sel_onehot;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] r_int_ack;
    logic               w_any;
    logic [c_ID_W-1:0]  w_sel;
    logic [c_ID_W-1:0]  r_sel_id;
    logic               r_cpu_intr;
    logic [VEC_W-1:0]   r_int_vec;
    logic [VEC_W-1:0]   w_vec;
    intc_state_t        r_state;
    intc_state_t        w_state_nxt;
    logic               w_take;
    logic               w_grant;
    logic               w_ack;

    // ------------------------------------------------------------------
    // Edge capture. The delay flop keeps following irq_in through reset so
    // a line still held high when reset releases is not seen as a new edge;
    // that source is re-latched only after it drops and rises again.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        r_irq_q <= irq_in;
    end

    assign w_rise = irq_in & ~r_irq_q;

    // Set wins over clear: an edge arriving during the ACK of the same
    // source leaves it pending for a second request.
    assign w_clr = w_ack ? w_sel_onehot : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mask <= '1;
        end else if (mask_wr) begin
            r_mask <= mask_in;
        end
    end

    assign w_elig = r_pending & ~r_mask;

    // ------------------------------------------------------------------
    // Priority select
    // ------------------------------------------------------------------
`ifdef INTC_ROTATE_PRIO_EN
    logic [c_ID_W-1:0] r_rr_ptr;

    // After servicing source k, k+1 (mod NUM_SRC) becomes highest priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_ack) begin
            r_rr_ptr <= (r_sel_id == c_ID_W'(NUM_SRC - 1)) ? '0 : r_sel_id + 1'b1;
        end
    end

    intc_prio_sel #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (c_ID_W)
    ) u_prio_sel (
        .elig    (w_elig),
        .rr_ptr  (r_rr_ptr),
        .any     (w_any),
        .sel_id  (w_sel)
    );
`else
    intc_prio_sel #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (c_ID_W)
    ) u_prio_sel (
        .elig    (w_elig),
        .any     (w_any),
        .sel_id  (w_sel)
    );
`endif

    always_comb begin
        w_sel_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_sel_onehot[i] = (r_sel_id == c_ID_W'(i));
        end
    end

    // Vector add at VEC_W bits, wrapping naturally.
    assign w_vec = VEC_BASE + (VEC_W'(r_sel_id) << 2);

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_grant     = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            IDLE: begin
                // cpu_inta while idle is ignored.
                if (w_any) begin
                    w_take      = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (cpu_inta) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                w_ack       = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (!cpu_inta) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Selection is frozen at the IDLE->REQ decision; later mask writes or
    // higher-priority edges do not retarget an open request.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sel_id   <= '0;
            r_cpu_intr <= 1'b0;
            r_int_vec  <= '0;
            r_int_ack  <= '0;
        end else begin
            if (w_take) begin
                r_sel_id <= w_sel;
            end

            if (w_take) begin
                r_cpu_intr <= 1'b1;
            end else if (w_ack) begin
                r_cpu_intr <= 1'b0;
            end

            if (w_grant) begin
                r_int_vec <= w_vec;
            end

            // Registered so the pulse coincides exactly with the ACK state.
            r_int_ack <= w_grant ? w_sel_onehot : '0;
        end
    end

    assign int_ack  = r_int_ack;
    assign cpu_intr = r_cpu_intr;
    assign int_vec  = r_int_vec;
    assign pending  = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_io_intr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_io_intr_ctrl                                                 |
// | Purpose  : Directed self-checking bench for io_intr_ctrl (NUM_SRC=4,       |
// |            VEC_W=32). Expected values are hand-computed; the rotation      |
// |            expectations follow INTC_ROTATE_PRIO_EN when defined.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_io_intr_ctrl;

    logic        clock;
    logic        reset;
    logic [3:0]  irq_in;
    logic [3:0]  int_ack;
    logic        mask_wr;
    logic [3:0]  mask_in;
    logic        cpu_intr;
    logic        cpu_inta;
    logic [31:0] int_vec;
    logic [3:0]  pending;

    int n_chk  = 0;
    int n_pass = 0;

    io_intr_ctrl #(
        .NUM_SRC  (4),
        .VEC_W    (32),
        .VEC_BASE (32'h0000_0F00)
    ) u_dut (
        .clock    (clock),
        .reset    (reset),
        .irq_in   (irq_in),
        .int_ack  (int_ack),
        .mask_wr  (mask_wr),
        .mask_in  (mask_in),
        .cpu_intr (cpu_intr),
        .cpu_inta (cpu_inta),
        .int_vec  (int_vec),
        .pending  (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance n clocks; inputs driven and outputs sampled 1ns after posedge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_wr = 1'b1;
        mask_in = m;
        tick(1);
        mask_wr = 1'b0;
    endtask

    // Expects the DUT in REQ with cpu_intr high; runs inta through ACK/WAIT.
    task automatic service(input string tag, input logic [31:0] ev,
                           input logic [3:0] ea, input logic [3:0] ep);
        cpu_inta = 1'b1;
        tick(1);
        chk({tag, ".vec"},      int_vec,  ev);
        chk({tag, ".ack"},      {28'd0, int_ack}, {28'd0, ea});
        chk({tag, ".intr_ack"}, {31'd0, cpu_intr}, 32'd1);
        tick(1);
        chk({tag, ".ack_off"},  {28'd0, int_ack}, 32'd0);
        chk({tag, ".intr_off"}, {31'd0, cpu_intr}, 32'd0);
        chk({tag, ".pend"},     {28'd0, pending}, {28'd0, ep});
        chk({tag, ".vec_hold"}, int_vec,  ev);
        cpu_inta = 1'b0;
        tick(1);
        chk({tag, ".idle_intr"}, {31'd0, cpu_intr}, 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        irq_in   = 4'b1111;
        mask_wr  = 1'b0;
        mask_in  = 4'b0000;
        cpu_inta = 1'b0;

        // 1. reset with all lines high
        tick(2);
        chk("rst.intr", {31'd0, cpu_intr}, 32'd0);
        chk("rst.ack",  {28'd0, int_ack},  32'd0);
        chk("rst.vec",  int_vec,           32'd0);
        chk("rst.pend", {28'd0, pending},  32'd0);
        reset = 1'b0;
        tick(3);
        chk("rst.held_pend", {28'd0, pending}, 32'd0);
        chk("rst.held_intr", {31'd0, cpu_intr}, 32'd0);
        irq_in = 4'b0000;
        tick(1);

        // 2. single source, latency and handshake
        write_mask(4'b0000);
        irq_in = 4'b0100;
        tick(1);
        chk("t2.pend1", {28'd0, pending}, 32'h4);
        chk("t2.intr1", {31'd0, cpu_intr}, 32'd0);
        tick(1);
        chk("t2.intr2", {31'd0, cpu_intr}, 32'd1);
        service("t2", 32'h0000_0F08, 4'b0100, 4'b0000);
        irq_in = 4'b0000;
        tick(1);

        // 3. two simultaneous sources
        irq_in = 4'b1010;
        tick(2);
        chk("t3.intr", {31'd0, cpu_intr}, 32'd1);
`ifdef INTC_ROTATE_PRIO_EN
        service("t3a", 32'h0000_0F0C, 4'b1000, 4'b0010);
        chk("t3.gap", {31'd0, cpu_intr}, 32'd0);
        tick(1);
        chk("t3.intr_b", {31'd0, cpu_intr}, 32'd1);
        service("t3b", 32'h0000_0F04, 4'b0010, 4'b0000);
`else
        service("t3a", 32'h0000_0F04, 4'b0010, 4'b1000);
        chk("t3.gap", {31'd0, cpu_intr}, 32'd0);
        tick(1);
        chk("t3.intr_b", {31'd0, cpu_intr}, 32'd1);
        service("t3b", 32'h0000_0F0C, 4'b1000, 4'b0000);
`endif
        irq_in = 4'b0000;
        tick(1);

        // 4. masked edge stays pending, unmask releases it
        write_mask(4'b0010);
        irq_in = 4'b0010;
        tick(3);
        chk("t4.pend",  {28'd0, pending}, 32'h2);
        chk("t4.masked", {31'd0, cpu_intr}, 32'd0);
        write_mask(4'b0000);
        tick(1);
        chk("t4.intr", {31'd0, cpu_intr}, 32'd1);
        service("t4", 32'h0000_0F04, 4'b0010, 4'b0000);
        irq_in = 4'b0000;
        tick(1);

        // 5. new edge on src0 during its own ACK cycle
        irq_in = 4'b0001;
        tick(2);
        chk("t5.intr", {31'd0, cpu_intr}, 32'd1);
        irq_in   = 4'b0000;
        cpu_inta = 1'b1;
        tick(1);
        chk("t5.vec", int_vec, 32'h0000_0F00);
        chk("t5.ack", {28'd0, int_ack}, 32'h1);
        irq_in = 4'b0001;
        tick(1);
        chk("t5.pend_kept", {28'd0, pending}, 32'h1);
        chk("t5.ack_off",   {28'd0, int_ack}, 32'd0);
        cpu_inta = 1'b0;
        tick(1);
        chk("t5.gap", {31'd0, cpu_intr}, 32'd0);
        tick(1);
        chk("t5.intr2", {31'd0, cpu_intr}, 32'd1);
        service("t5b", 32'h0000_0F00, 4'b0001, 4'b0000);
        irq_in = 4'b0000;
        tick(1);

        // 6. reset while in WAIT with inta held
        irq_in = 4'b1000;
        tick(2);
        chk("t6.intr", {31'd0, cpu_intr}, 32'd1);
        cpu_inta = 1'b1;
        tick(2);
        chk("t6.vec_wait", int_vec, 32'h0000_0F0C);
        reset = 1'b1;
        tick(1);
        chk("t6.intr", {31'd0, cpu_intr}, 32'd0);
        chk("t6.vec",  int_vec,           32'd0);
        chk("t6.ack",  {28'd0, int_ack},  32'd0);
        reset    = 1'b0;
        cpu_inta = 1'b0;
        tick(2);
        chk("t6.held_pend", {28'd0, pending}, 32'd0);
        chk("t6.held_intr", {31'd0, cpu_intr}, 32'd0);
        irq_in = 4'b0000;
        tick(1);

        // 7. service src0, then src0+src1 together
        write_mask(4'b0000);
        irq_in = 4'b0001;
        tick(2);
        chk("t7.intr", {31'd0, cpu_intr}, 32'd1);
        service("t7a", 32'h0000_0F00, 4'b0001, 4'b0000);
        irq_in = 4'b0000;
        tick(1);
        irq_in = 4'b0011;
        tick(1);
        chk("t7.pend", {28'd0, pending}, 32'h3);
        tick(1);
        chk("t7.intr2", {31'd0, cpu_intr}, 32'd1);
`ifdef INTC_ROTATE_PRIO_EN
        service("t7b", 32'h0000_0F04, 4'b0010, 4'b0001);
        tick(1);
        service("t7c", 32'h0000_0F00, 4'b0001, 4'b0000);
`else
        service("t7b", 32'h0000_0F00, 4'b0001, 4'b0010);
        tick(1);
        service("t7c", 32'h0000_0F04, 4'b0010, 4'b0000);
`endif

        // 8. inta in IDLE is ignored
        cpu_inta = 1'b1;
        tick(2);
        chk("t8.ack",  {28'd0, int_ack},  32'd0);
        chk("t8.intr", {31'd0, cpu_intr}, 32'd0);
`ifdef INTC_ROTATE_PRIO_EN
        chk("t8.vec", int_vec, 32'h0000_0F00);
`else
        chk("t8.vec", int_vec, 32'h0000_0F04);
`endif
        cpu_inta = 1'b0;
        irq_in   = 4'b0000;
        tick(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
